// File: rtl/sha3_padder_if.sv
// Stream bundle between the message source / SHA3 core and the padder.
// master: drives message words and the core's pacing indications.
// slave : the padder, which accepts words and presents rate blocks.
interface sha3_padder_if #(
  parameter int RATE_WORDS = 17,
  parameter int WORD_W     = 64
);
  logic [WORD_W-1:0]            in_data;
  logic [3:0]                   in_bytes;
  logic                         in_last;
  logic                         in_valid;
  logic                         in_ready;
  logic [RATE_WORDS*WORD_W-1:0] blk;
  logic                         blk_valid;
  logic                         blk_more;
  logic                         hash_next;
  logic                         hash_done;

  modport master (
    output in_data, in_bytes, in_last, in_valid, hash_next, hash_done,
    input  in_ready, blk, blk_valid, blk_more
  );

  modport slave (
    input  in_data, in_bytes, in_last, in_valid, hash_next, hash_done,
    output in_ready, blk, blk_valid, blk_more
  );
endinterface

// File: rtl/sha3_padder.sv
// SHA3-256 message padder: packs 64-bit words into 1088-bit rate blocks,
// applies pad10*1 with the domain byte, and paces blocks to the core.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | accept message words into the lane at the word counter
// PAD       | OR domain byte after the last data byte, 0x80 into byte 135
// SEND      | blk_valid pulse; blk/blk_more presented to the core
// WAIT_NEXT | core absorbing a non-final block; wait for hash_next
// WAIT_DONE | core absorbing the final block; wait for hash_done
module sha3_padder #(
  parameter int         RATE_WORDS = 17,
  parameter int         WORD_W     = 64,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input logic           clk,
  input logic           rst,
  sha3_padder_if.slave  bus
);
  localparam int BLK_W     = RATE_WORDS * WORD_W;
  localparam int WB        = WORD_W / 8;
  localparam int BLK_BYTES = BLK_W / 8;
  localparam int CW        = $clog2(RATE_WORDS);
  localparam int PW        = $clog2(BLK_BYTES);

  localparam logic [CW-1:0] LAST_LANE  = CW'(RATE_WORDS - 1);
  localparam logic [3:0]    FULL_BYTES = 4'(WB);

  localparam logic [2:0] S_FILL      = 3'd0;
  localparam logic [2:0] S_PAD       = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_WAIT_NEXT = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              blk_valid_q, blk_valid_d;
  logic              more_q, more_d;
  logic              extra_q, extra_d;
  logic [3:0]        last_bytes_q, last_bytes_d;

  logic [3:0]        nb;
  logic [6:0]        sh;
  logic [WORD_W-1:0] word_m;
  logic [PW-1:0]     pad_pos;

  // Clamp the byte count and zero every byte past it so stale data never leaks into blk.
  always_comb begin
    nb      = (bus.in_bytes > FULL_BYTES) ? FULL_BYTES : bus.in_bytes;
    sh      = {nb, 3'b000};
    word_m  = bus.in_data & ~({WORD_W{1'b1}} >> sh);
    pad_pos = PW'(cnt_q) * PW'(WB) + PW'(last_bytes_q);
  end

  // Next-state, lane packing and padding.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    more_d       = more_q;
    extra_d      = extra_q;
    last_bytes_d = last_bytes_q;

    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          for (int i = 0; i < RATE_WORDS; i++) begin
            if (CW'(i) == cnt_q) blk_d[BLK_W-1-WORD_W*i -: WORD_W] = word_m;
          end
          if (bus.in_last) begin
            last_bytes_d = nb;
            if (cnt_q == LAST_LANE && nb == FULL_BYTES) begin
              // Full final block: padding has to travel in a block of its own.
              state_d = S_SEND;
              more_d  = 1'b1;
              extra_d = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = S_PAD;
            end
          end else if (cnt_q == LAST_LANE) begin
            state_d = S_SEND;
            more_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAD: begin
        // Lanes after the last word are still zero from the clear on FILL entry.
        for (int i = 0; i < BLK_BYTES; i++) begin
          if (PW'(i) == pad_pos) blk_d[BLK_W-1-8*i -: 8] = blk_d[BLK_W-1-8*i -: 8] | DOMAIN;
        end
        blk_d[7:0] = blk_d[7:0] | 8'h80;
        more_d     = 1'b0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        state_d = more_q ? S_WAIT_NEXT : S_WAIT_DONE;
      end
      S_WAIT_NEXT: begin
        if (bus.hash_next) begin
          if (extra_q) begin
            blk_d                = '0;
            blk_d[BLK_W-1 -: 8]  = DOMAIN;
            blk_d[7:0]           = 8'h80;
            more_d               = 1'b0;
            extra_d              = 1'b0;
            state_d              = S_SEND;
          end else begin
            state_d = S_FILL;
            cnt_d   = '0;
            blk_d   = '0;
          end
        end
      end
      S_WAIT_DONE: begin
        if (bus.hash_done) begin
          state_d = S_FILL;
          cnt_d   = '0;
          blk_d   = '0;
        end
      end
      default: begin
        state_d = S_FILL;
        cnt_d   = '0;
        blk_d   = '0;
      end
    endcase

    blk_valid_d = (state_d == S_SEND);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      blk_q        <= '0;
      blk_valid_q  <= 1'b0;
      more_q       <= 1'b0;
      extra_q      <= 1'b0;
      last_bytes_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      blk_valid_q  <= blk_valid_d;
      more_q       <= more_d;
      extra_q      <= extra_d;
      last_bytes_q <= last_bytes_d;
    end
  end

  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.blk       = blk_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_more  = more_q;
endmodule

// File: tb/tb_sha3_padder.sv
// Scoreboard bench for sha3_padder: stimulus pushes expected blocks,
// a monitor compares each blk_valid pulse, a core model paces the padder.
module tb_sha3_padder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha3_padder_if bus ();
  sha3_padder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1087:0] blk;
    logic          more;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    msg [0:511];
  logic          busy      = 1'b0;
  logic          resp_hold = 1'b0;
  logic [1087:0] last_blk  = '0;
  logic [1087:0] hand_pad;
  logic [1087:0] hand_abc;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1087:0] act, input logic [1087:0] exp);
    bit shown;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      shown = 0;
      for (int i = 0; i < 17; i++) begin
        if (!shown && act[1087-64*i -: 64] !== exp[1087-64*i -: 64]) begin
          $display("FAIL %s lane %0d: got %h expected %h", name, i,
                   act[1087-64*i -: 64], exp[1087-64*i -: 64]);
          shown = 1;
        end
      end
    end
  endtask

  task automatic fill_msg(input int seed);
    for (int i = 0; i < 512; i++) msg[i] = 8'((i * 37 + seed) & 255);
  endtask

  // Byte-level pad10*1 reference over the whole message.
  task automatic push_expected(input int len);
    int nblk;
    nblk = len / 136 + 1;
    for (int b = 0; b < nblk; b++) begin
      exp_t       e;
      logic [7:0] v;
      e.blk = '0;
      for (int k = 0; k < 136; k++) begin
        int idx;
        idx = b * 136 + k;
        v = (idx < len) ? msg[idx] : 8'h00;
        if (idx == len) v = v | 8'h06;
        if (b == nblk - 1 && k == 135) v = v | 8'h80;
        e.blk[1087-8*k -: 8] = v;
      end
      e.more = (b != nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // Present one word at a negedge; returns on the negedge after the transfer edge.
  task automatic drive_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int guard;
    bus.in_data  = d;
    bus.in_bytes = nb;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", guard);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int len, input bit rnd);
    int          nw;
    int          nb;
    logic [63:0] d;
    bit          last;
    push_expected(len);
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      last = (w == nw - 1);
      nb   = last ? len - 8 * w : 8;
      for (int j = 0; j < 8; j++) d[63-8*j -: 8] = (j < nb) ? msg[8*w+j] : 8'hA5;
      if (rnd) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 64'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drive_word(d, 4'(nb), last);
      if ((w % 17) == 16 && (!last || nb == 8)) begin
        chk_bit("lat_full_t1", bus.blk_valid, 1'b1);
      end else if (last) begin
        chk_bit("lat_pad_t1", bus.blk_valid, 1'b0);
        @(negedge clk);
        chk_bit("lat_pad_t2", bus.blk_valid, 1'b1);
      end
    end
  endtask

  task automatic wait_idle();
    int stable;
    int guard;
    stable = 0;
    guard  = 0;
    while (stable < 2 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (exp_q.size() == 0 && !busy) stable++;
      else stable = 0;
    end
    n_tests++;
    if (stable < 2) begin
      n_fail++;
      $display("FAIL idle_timeout: got %0d blocks pending expected 0", exp_q.size());
    end
    chk_bit("idle_in_ready", bus.in_ready, 1'b1);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.blk_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_blk: got blk_valid=1 more=%b expected no block", bus.blk_more);
        end else begin
          e = exp_q.pop_front();
          last_blk = bus.blk;
          chk_blk("blk", bus.blk, e.blk);
          chk_bit("blk_more", bus.blk_more, e.more);
        end
      end
    end
  end

  // Core model: answers each block after a short absorb delay.
  initial begin
    int   d;
    int   i;
    int   viol;
    logic more;
    bit   aborted;
    bus.hash_next = 1'b0;
    bus.hash_done = 1'b0;
    forever begin
      @(negedge clk);
      while (!rst && bus.blk_valid) begin
        busy    = 1'b1;
        more    = bus.blk_more;
        d       = $urandom_range(1, 4);
        i       = 0;
        viol    = 0;
        aborted = 0;
        while ((i < d || resp_hold) && !aborted) begin
          @(negedge clk);
          if (rst) aborted = 1;
          else if (bus.in_ready || bus.blk_valid) viol++;
          i++;
        end
        if (!aborted) begin
          if (more) bus.hash_next = 1'b1;
          else bus.hash_done = 1'b1;
          @(negedge clk);
          bus.hash_next = 1'b0;
          bus.hash_done = 1'b0;
          n_tests++;
          if (viol != 0) begin
            n_fail++;
            $display("FAIL wait_hold: got %0d cycles with in_ready/blk_valid expected 0", viol);
          end
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_data  = '0;
    bus.in_bytes = '0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    hand_pad = '0;
    hand_pad[1087 -: 8] = 8'h06;
    hand_pad[7:0]       = 8'h80;
    hand_abc = '0;
    hand_abc[1087 -: 32] = 32'h61626306;
    hand_abc[7:0]        = 8'h80;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_bit("rst_blk_valid", bus.blk_valid, 1'b0);
    chk_bit("rst_blk_more", bus.blk_more, 1'b0);
    chk_bit("rst_in_ready", bus.in_ready, 1'b1);
    chk_blk("rst_blk", bus.blk, '0);
    rst = 1'b0;

    fill_msg(11);
    send_msg(0, 0);
    wait_idle();
    chk_blk("empty_hand", last_blk, hand_pad);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    wait_idle();
    chk_blk("abc_hand", last_blk, hand_abc);

    fill_msg(5);
    send_msg(64, 0);
    wait_idle();

    fill_msg(23);
    send_msg(135, 0);
    wait_idle();
    chk_byte("b135_byte135", last_blk[7:0], 8'h86);

    fill_msg(41);
    send_msg(136, 0);
    wait_idle();
    chk_blk("b136_pad_only", last_blk, hand_pad);

    fill_msg(97);
    send_msg(300, 1);
    wait_idle();

    // Reset while word 9 is being offered in FILL.
    fill_msg(3);
    for (int w = 0; w < 9; w++) drive_word({msg[8*w], msg[8*w+1], msg[8*w+2], msg[8*w+3],
                                            msg[8*w+4], msg[8*w+5], msg[8*w+6], msg[8*w+7]},
                                           4'd8, 1'b0);
    bus.in_data  = 64'h0123456789abcdef;
    bus.in_bytes = 4'd8;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_blk("rst_fill_blk", bus.blk, '0);
    chk_bit("rst_fill_blk_valid", bus.blk_valid, 1'b0);
    chk_bit("rst_fill_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    wait_idle();
    chk_blk("abc_after_fill_rst", last_blk, hand_abc);

    // Reset while the padder waits for hash_next.
    fill_msg(59);
    resp_hold = 1'b1;
    send_msg(136, 0);
    repeat (3) @(negedge clk);
    chk_bit("wait_next_in_ready", bus.in_ready, 1'b0);
    chk_bit("wait_next_no_blk", bus.blk_valid, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_blk("rst_wait_blk", bus.blk, '0);
    chk_bit("rst_wait_blk_valid", bus.blk_valid, 1'b0);
    chk_bit("rst_wait_blk_more", bus.blk_more, 1'b0);
    chk_bit("rst_wait_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    resp_hold = 1'b0;

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0);
    wait_idle();
    chk_blk("abc_after_wait_rst", last_blk, hand_abc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
